press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter LONG_CYC, default 100: consecutive high db_level cycles that make a long press.
REQ-003 Parameter GAP_CYC, default 30: maximum release-to-repress cycles that make a double press.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: asynchronous reset, active-low (0 = reset).
REQ-006 Port db_level, input, 1: debounced switch level from the debounce stage.
REQ-007 Port db_tick, input, 1: one-cycle pulse from the debounce stage on a debounced rising edge.
REQ-008 Port short_press, output, 1: one-cycle pulse when a short press is classified.
REQ-009 Port long_press, output, 1: one-cycle pulse when a long press is classified.
REQ-010 Port double_press, output, 1: one-cycle pulse when a double press is classified (tied 0 without the macro).
REQ-011 Port busy, output, 1: high whenever the state is not IDLE.
REQ-012 Port press_count, output, 8: count of classified events, saturating.

Function
REQ-013 FSM states SHALL be IDLE, PRESSED, HELD and WAIT_GAP; WAIT_GAP exists only with the macro.
REQ-014 IDLE: db_tick=1 -> PRESSED, hold counter loaded to 1; db_level without db_tick SHALL be ignored.
REQ-015 PRESSED, db_level=1: hold counter increments; when hold counter = LONG_CYC -> assert long_press next cycle, go to HELD.
REQ-016 PRESSED, db_level=0 (release) before threshold: macro off -> assert short_press next cycle, go to IDLE; macro on -> go to WAIT_GAP, gap counter cleared.
REQ-017 If release and threshold coincide on the same edge, release SHALL win (short/gap path, no long_press).
REQ-018 HELD: stay until db_level=0, then go to IDLE; no outputs pulse in HELD.
REQ-019 WAIT_GAP: db_tick within GAP_CYC cycles -> double_press next cycle, go to HELD; gap counter reaching GAP_CYC with no db_tick -> short_press next cycle, go to IDLE.
REQ-020 db_tick received in PRESSED or HELD SHALL be ignored.
REQ-021 All outputs SHALL be registered; at most one of short_press, long_press and double_press SHALL be high in any cycle.
REQ-022 press_count SHALL increment by 1 on each short, long or double event and saturate at 255.
REQ-023 The hold and gap counters SHALL be wide enough (clog2) for their parameters; they SHALL NOT wrap before the compare.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, counters 0, short_press=0, long_press=0, double_press=0, busy=0 and press_count=0.
REQ-025 A reset during PRESSED or WAIT_GAP SHALL discard the pending press with no pulse.
REQ-026 After reset release, the first db_tick SHALL be honoured normally.

Configuration
REQ-027 Macro PRESS_DOUBLE_CLICK_EN defined: WAIT_GAP and double_press are implemented per REQ-016 and REQ-019.
REQ-028 Macro PRESS_DOUBLE_CLICK_EN undefined: WAIT_GAP logic is absent, double_press is tied 0, and short_press fires one cycle after release.

Verification (LONG_CYC=8, GAP_CYC=4, 10 ns clock)
REQ-029 Scenario: hold rst=0 with random db_level/db_tick -> all outputs stay 0; release rst -> outputs remain 0 until a db_tick.
REQ-030 Scenario (macro off): db_tick, level high 3 cycles, release -> short_press one cycle after the release edge; press_count=1; busy back to 0.
REQ-031 Scenario: db_tick, level held high 12 cycles -> exactly one long_press, 8 cycles after db_tick; no short_press on release; press_count=1.
REQ-032 Scenario (macro on): press 2 cycles, release 2 cycles, db_tick again -> double_press once, no short_press; press_count=1.
REQ-033 Scenario (macro on): press 2 cycles, release 6 cycles -> short_press when gap counter hits 4; no double_press.
REQ-034 Scenario: rst=0 mid-PRESSED gives no pulse and state IDLE; then 260 short presses -> press_count holds at 255.

Source files
------------

// File: rtl/press_classifier.sv
// press_classifier
//
// Classifies debounced button activity into short, long and (optionally)
// double presses.
//
// Build option: define PRESS_DOUBLE_CLICK_EN to add the WAIT_GAP state and
// the double_press output. Without it, WAIT_GAP is absent, double_press is
// tied 0, and short_press fires one cycle after release.
//
// Parameters
//   LONG_CYC  consecutive high db_level cycles (counting the db_tick cycle)
//             that make a long press
//   GAP_CYC   release-to-repress window, in cycles, for a double press
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low (0 = reset)
//   db_level      debounced switch level
//   db_tick       one-cycle pulse on a debounced rising edge
//   short_press   one-cycle pulse: short press classified
//   long_press    one-cycle pulse: long press classified
//   double_press  one-cycle pulse: double press classified
//   busy          high whenever the FSM is not in IDLE
//   press_count   saturating count of classified events
//   state_dbg     current FSM state encoding, for observation only
//                 (0 IDLE, 1 PRESSED, 2 HELD, 3 WAIT_GAP)
//
// Handshake: there is no valid/ready flow control. db_tick is a
// single-cycle strobe sampled on the rising clock edge and is consumed only
// in IDLE (and in WAIT_GAP when enabled); the three event outputs are
// single-cycle strobes with no back-pressure.
module press_classifier #(
    parameter int LONG_CYC = 100,
    parameter int GAP_CYC  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       db_level,
    input  logic       db_tick,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic       busy,
    output logic [7:0] press_count,
    output logic [1:0] state_dbg
);

    // Counters hold values up to and including their threshold, so they
    // never wrap before the compare.
    localparam int HOLD_W = $clog2(LONG_CYC + 1);

`ifdef PRESS_DOUBLE_CLICK_EN
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2,
        WAIT_GAP = 2'd3
    } state_t;

    logic [GAP_W-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;
`endif

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign state_dbg = state;

`ifndef PRESS_DOUBLE_CLICK_EN
    assign double_press = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
            busy        <= 1'b0;
            press_count <= 8'd0;
`ifdef PRESS_DOUBLE_CLICK_EN
            gap_cnt      <= '0;
            double_press <= 1'b0;
`endif
        end else begin
            // Event outputs are strobes: cleared every cycle unless set below.
            short_press <= 1'b0;
            long_press  <= 1'b0;
`ifdef PRESS_DOUBLE_CLICK_EN
            double_press <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A level that rises without a tick is not a new press.
                    if (db_tick) begin
                        state    <= PRESSED;
                        hold_cnt <= HOLD_W'(1);
                        busy     <= 1'b1;
                    end
                end

                PRESSED: begin
                    // Release is checked first so that a release landing on
                    // the threshold edge is classified as short.
                    if (!db_level) begin
`ifdef PRESS_DOUBLE_CLICK_EN
                        state   <= WAIT_GAP;
                        gap_cnt <= '0;
`else
                        state       <= IDLE;
                        busy        <= 1'b0;
                        short_press <= 1'b1;
                        press_count <= sat_inc(press_count);
`endif
                    end else if (hold_cnt == HOLD_W'(LONG_CYC)) begin
                        state       <= HELD;
                        long_press  <= 1'b1;
                        press_count <= sat_inc(press_count);
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                HELD: begin
                    // Button is still down after a long or double press;
                    // wait silently for release.
                    if (!db_level) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

`ifdef PRESS_DOUBLE_CLICK_EN
                WAIT_GAP: begin
                    // The window covers the GAP_CYC cycles in which gap_cnt
                    // reads 0..GAP_CYC-1; once it reads GAP_CYC the timeout
                    // takes priority over a late tick.
                    if (gap_cnt == GAP_W'(GAP_CYC)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        short_press <= 1'b1;
                        press_count <= sat_inc(press_count);
                    end else if (db_tick) begin
                        state        <= HELD;
                        double_press <= 1'b1;
                        press_count  <= sat_inc(press_count);
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
`timescale 1ns/1ps
module tb_press_classifier;
    localparam int LONG_CYC = 8;
    localparam int GAP_CYC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       db_level = 1'b0;
    logic       db_tick = 1'b0;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       busy;
    logic [7:0] press_count;
    logic [1:0] state_dbg;

    int checks    = 0;
    int failures  = 0;
    int n_short   = 0;
    int n_long    = 0;
    int n_double  = 0;
    int exp_count = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    press_classifier #(
        .LONG_CYC(LONG_CYC),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .db_level    (db_level),
        .db_tick     (db_tick),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .busy        (busy),
        .press_count (press_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts event strobes and checks they are exclusive.
    always @(negedge clk) begin
        if (short_press)  n_short++;
        if (long_press)   n_long++;
        if (double_press) n_double++;
        checks++;
        assert ((int'(short_press) + int'(long_press) + int'(double_press)) <= 1) else begin
            failures++;
            $error("FAIL exclusive observed=%0d%0d%0d expected=at_most_one", short_press, long_press, double_press);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        n_short  = 0;
        n_long   = 0;
        n_double = 0;
    endtask

    task automatic bump();
        exp_count = (exp_count == 255) ? 255 : exp_count + 1;
    endtask

    task automatic check_counts(input string tag, input int s, input int l, input int d);
        check({tag, "_nshort"},  n_short,  s);
        check({tag, "_nlong"},   n_long,   l);
        check({tag, "_ndouble"}, n_double, d);
        check({tag, "_count"},   press_count, exp_count);
        check({tag, "_busy"},    busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_short"},  short_press, 0);
        check({tag, "_long"},   long_press, 0);
        check({tag, "_double"}, double_press, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_count"},  press_count, 0);
        check({tag, "_state"},  state_dbg, 0);
    endtask

    // Short press: tick + 2 high cycles, then release and drain.
    task automatic short_press_seq();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0; step();
        db_level = 1'b0; step();
`ifdef PRESS_DOUBLE_CLICK_EN
        repeat (6) step();
`else
        step();
`endif
        bump();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset held with random inputs: everything stays 0.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            db_level = 1'($urandom_range(0, 1));
            db_tick  = 1'($urandom_range(0, 1));
            step();
            check_quiet("in_reset");
        end
        db_tick = 1'b0; db_level = 1'b0;
        step();
        rst = 1'b1;
        // Level activity without a tick is ignored in IDLE.
        for (int i = 0; i < 6; i++) begin
            db_level = 1'($urandom_range(0, 1));
            step();
            check_quiet("idle_no_tick");
        end
        db_level = 1'b0;
        step();
        clear_pulses();

        // Short press: tick, level high 3 cycles, release.
        db_tick = 1'b1; db_level = 1'b1; step();
        check("short_busy_up", busy, 1);
        check("short_state_pressed", state_dbg, 1);
        db_tick = 1'b0; step(); step();
        db_level = 1'b0; step();
`ifdef PRESS_DOUBLE_CLICK_EN
        check("short_gap_no_pulse", short_press, 0);
        check("short_state_gap", state_dbg, 3);
        repeat (4) step();
        check("short_gap_before_timeout", short_press, 0);
        step();
`endif
        check("short_pulse", short_press, 1);
        bump();
        check("short_busy_down", busy, 0);
        check("short_count", press_count, exp_count);
        step();
        check("short_pulse_one_cycle", short_press, 0);
        check_counts("short", 1, 0, 0);

        // Long press: 12 high cycles, with ticks in PRESSED and HELD ignored.
        clear_pulses();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0;
        repeat (3) step();
        db_tick = 1'b1; step();
        db_tick = 1'b0;
        repeat (3) step();
        check("long_not_early", long_press, 0);
        step();
        check("long_pulse", long_press, 1);
        check("long_state_held", state_dbg, 2);
        bump();
        check("long_count", press_count, exp_count);
        db_tick = 1'b1; step();
        db_tick = 1'b0;
        check("long_pulse_one_cycle", long_press, 0);
        step(); step();
        db_level = 1'b0; step();
        check("long_release_state", state_dbg, 0);
        step();
        check_counts("long", 0, 1, 0);

        // Release on the threshold edge: release wins, no long press.
        clear_pulses();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0;
        repeat (7) step();
        db_level = 1'b0; step();
        check("coincide_no_long", long_press, 0);
`ifdef PRESS_DOUBLE_CLICK_EN
        check("coincide_state_gap", state_dbg, 3);
        repeat (5) step();
`endif
        check("coincide_short", short_press, 1);
        bump();
        step();
        check_counts("coincide", 1, 0, 0);

`ifdef PRESS_DOUBLE_CLICK_EN
        // Double press: press 2, release 2, tick again.
        clear_pulses();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0; step();
        db_level = 1'b0; step(); step();
        db_tick = 1'b1; db_level = 1'b1; step();
        check("double_pulse", double_press, 1);
        check("double_no_short", short_press, 0);
        check("double_state_held", state_dbg, 2);
        bump();
        db_tick = 1'b0; step();
        check("double_one_cycle", double_press, 0);
        db_level = 1'b0; step();
        step();
        check_counts("double", 0, 0, 1);

        // Tick in the last window cycle still counts as double.
        clear_pulses();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0; step();
        db_level = 1'b0; step();
        repeat (3) step();
        db_tick = 1'b1; db_level = 1'b1; step();
        check("double_edge_pulse", double_press, 1);
        bump();
        db_tick = 1'b0; db_level = 1'b0; step();
        step();
        check_counts("double_edge", 0, 0, 1);

        // Gap timeout: press 2, release 6 -> short when gap hits 4.
        clear_pulses();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0; step();
        db_level = 1'b0; step();
        repeat (4) step();
        check("gap_timeout_not_early", short_press, 0);
        step();
        check("gap_timeout_short", short_press, 1);
        bump();
        step();
        check_counts("gap_timeout", 1, 0, 0);
`endif

        // Async reset mid-PRESSED discards the press.
        clear_pulses();
        db_tick = 1'b1; db_level = 1'b1; step();
        db_tick = 1'b0; step();
        rst = 1'b0;
        #1;
        check_quiet("async_reset");
        exp_count = 0;
        step();
        rst = 1'b1;
        db_level = 1'b0;
        repeat (8) step();
        check_counts("post_reset", 0, 0, 0);

        // Saturation of press_count at 255.
        for (int i = 0; i < 260; i++) begin
            short_press_seq();
            check("sat_count", press_count, exp_count);
        end
        check("sat_final", press_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
